// File: rtl/vcache_req_latency_monitor_if.sv
// Observed request/response handshake of one vcache plus the shared cycle counter.
// Only the monitor's own outputs are left out; the monitor never drives any of these.
interface vcache_req_latency_monitor_if;
    logic        v_i;
    logic        ready_o;
    logic        v_o;
    logic        yumi_i;
    logic [31:0] global_ctr_i;

    modport master (output v_i, ready_o, v_o, yumi_i, global_ctr_i);
    modport slave  (input  v_i, ready_o, v_o, yumi_i, global_ctr_i);
endinterface

// File: rtl/vcache_req_latency_monitor.sv
// Passive vcache request latency monitor: timestamps accepted requests in an in-order FIFO,
// retires them on response and keeps counts, stalls, total/max latency and a snapshot copy.
module vcache_req_latency_monitor #(
    parameter int data_width_p = 32,
    parameter int max_out_p    = 4,
    parameter int ctr_width_p  = 32
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    vcache_req_latency_monitor_if.slave     mon,
    input  logic                            snap_v_i,
    input  logic [data_width_p-1:0]         snap_tag_i,
    output logic                            snap_v_o,
    output logic [data_width_p-1:0]         snap_tag_o,
    output logic [ctr_width_p-1:0]          req_count_o,
    output logic [ctr_width_p-1:0]          resp_count_o,
    output logic [ctr_width_p-1:0]          stall_count_o,
    output logic [ctr_width_p-1:0]          total_lat_o,
    output logic [ctr_width_p-1:0]          max_lat_o,
    output logic [$clog2(max_out_p):0]      outstanding_o,
    output logic                            overflow_o,
    output logic                            underflow_o
);

    localparam int ptr_width_lp = $clog2(max_out_p);
    localparam int occ_width_lp = ptr_width_lp + 1;

    localparam logic [ptr_width_lp-1:0] ptr_one_lp  = ptr_width_lp'(1'b1);
    localparam logic [occ_width_lp-1:0] occ_one_lp  = occ_width_lp'(1'b1);
    localparam logic [occ_width_lp-1:0] occ_zero_lp = {occ_width_lp{1'b0}};
    localparam logic [occ_width_lp-1:0] occ_full_lp = occ_width_lp'(max_out_p);
    localparam logic [ctr_width_p-1:0]  ctr_one_lp  = ctr_width_p'(1'b1);
    localparam logic [ctr_width_p-1:0]  ctr_ones_lp = {ctr_width_p{1'b1}};
    localparam logic [ctr_width_p-1:0]  ctr_zero_lp = {ctr_width_p{1'b0}};

    // live state
    logic [31:0]             ts_mem_r [max_out_p];
    logic [ptr_width_lp-1:0] head_r, tail_r;
    logic [occ_width_lp-1:0] occ_r;
    logic [ctr_width_p-1:0]  req_r, resp_r, stall_r, total_r, max_r;
    logic                    ovf_r, unf_r;

    // snapshot state
    logic                    snap_v_r;
    logic [data_width_p-1:0] snap_tag_r;
    logic [ctr_width_p-1:0]  snap_req_r, snap_resp_r, snap_stall_r, snap_total_r, snap_max_r;

    // combinational decode
    logic                    accept_s, respond_s, stall_s;
    logic                    full_s, empty_s, push_s, pop_s;
    logic [31:0]             head_ts_s, lat_wide_s;
    logic [ctr_width_p-1:0]  lat_s;
    logic [ctr_width_p:0]    lat_sum_s;

    // next-state values
    logic [ptr_width_lp-1:0] head_next_s, tail_next_s;
    logic [occ_width_lp-1:0] occ_next_s;
    logic [ctr_width_p-1:0]  req_next_s, resp_next_s, stall_next_s, total_next_s, max_next_s;
    logic                    ovf_next_s, unf_next_s;

    // Handshake decode and head-entry latency; modulo-2^32 subtraction handles counter wrap.
    always_comb begin
        accept_s   = mon.v_i & mon.ready_o;
        respond_s  = mon.v_o & mon.yumi_i;
        stall_s    = mon.v_i & ~mon.ready_o;
        full_s     = (occ_r == occ_full_lp);
        empty_s    = (occ_r == occ_zero_lp);
        pop_s      = respond_s & ~empty_s;
        // a full FIFO still takes the push when the head leaves in the same cycle
        push_s     = accept_s & (~full_s | respond_s);
        head_ts_s  = ts_mem_r[head_r];
        lat_wide_s = mon.global_ctr_i - head_ts_s;
        lat_s      = ctr_width_p'(lat_wide_s);
        lat_sum_s  = {1'b0, total_r} + {1'b0, lat_s};
    end

    // Next values of pointers, occupancy, counters and sticky flags.
    always_comb begin
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        occ_next_s   = occ_r;
        req_next_s   = req_r;
        resp_next_s  = resp_r;
        stall_next_s = stall_r;
        total_next_s = total_r;
        max_next_s   = max_r;
        ovf_next_s   = ovf_r;
        unf_next_s   = unf_r;

        if (push_s) begin
            tail_next_s = tail_r + ptr_one_lp;
        end else begin
            tail_next_s = tail_r;
        end

        if (pop_s) begin
            head_next_s = head_r + ptr_one_lp;
        end else begin
            head_next_s = head_r;
        end

        case ({push_s, pop_s})
            2'b10:   occ_next_s = occ_r + occ_one_lp;
            2'b01:   occ_next_s = occ_r - occ_one_lp;
            default: occ_next_s = occ_r;
        endcase

        if (accept_s) begin
            req_next_s = req_r + ctr_one_lp;
        end else begin
            req_next_s = req_r;
        end

        if (accept_s && !push_s) begin
            ovf_next_s = 1'b1;
        end else begin
            ovf_next_s = ovf_r;
        end

        if (respond_s) begin
            resp_next_s = resp_r + ctr_one_lp;
        end else begin
            resp_next_s = resp_r;
        end

        if (respond_s && empty_s) begin
            unf_next_s = 1'b1;
        end else begin
            unf_next_s = unf_r;
        end

        if (pop_s) begin
            if (lat_sum_s[ctr_width_p]) begin
                total_next_s = ctr_ones_lp;
            end else begin
                total_next_s = lat_sum_s[ctr_width_p-1:0];
            end
            if (lat_s > max_r) begin
                max_next_s = lat_s;
            end else begin
                max_next_s = max_r;
            end
        end else begin
            total_next_s = total_r;
            max_next_s   = max_r;
        end

        if (stall_s && (stall_r != ctr_ones_lp)) begin
            stall_next_s = stall_r + ctr_one_lp;
        end else begin
            stall_next_s = stall_r;
        end
    end

    // Timestamp storage; contents are meaningless outside head..tail so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            ts_mem_r[tail_r] <= mon.global_ctr_i;
        end
    end

    // Live counters, FIFO pointers and sticky flags.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_r  <= {ptr_width_lp{1'b0}};
            tail_r  <= {ptr_width_lp{1'b0}};
            occ_r   <= occ_zero_lp;
            req_r   <= ctr_zero_lp;
            resp_r  <= ctr_zero_lp;
            stall_r <= ctr_zero_lp;
            total_r <= ctr_zero_lp;
            max_r   <= ctr_zero_lp;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            occ_r   <= occ_next_s;
            req_r   <= req_next_s;
            resp_r  <= resp_next_s;
            stall_r <= stall_next_s;
            total_r <= total_next_s;
            max_r   <= max_next_s;
            ovf_r   <= ovf_next_s;
            unf_r   <= unf_next_s;
        end
    end

    // Snapshot copies the pre-edge live values, so this edge's events show up in the next one.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            snap_v_r     <= 1'b0;
            snap_tag_r   <= {data_width_p{1'b0}};
            snap_req_r   <= ctr_zero_lp;
            snap_resp_r  <= ctr_zero_lp;
            snap_stall_r <= ctr_zero_lp;
            snap_total_r <= ctr_zero_lp;
            snap_max_r   <= ctr_zero_lp;
        end else begin
            snap_v_r <= snap_v_i;
            if (snap_v_i) begin
                snap_tag_r   <= snap_tag_i;
                snap_req_r   <= req_r;
                snap_resp_r  <= resp_r;
                snap_stall_r <= stall_r;
                snap_total_r <= total_r;
                snap_max_r   <= max_r;
            end
        end
    end

    assign snap_v_o      = snap_v_r;
    assign snap_tag_o    = snap_tag_r;
    assign req_count_o   = snap_req_r;
    assign resp_count_o  = snap_resp_r;
    assign stall_count_o = snap_stall_r;
    assign total_lat_o   = snap_total_r;
    assign max_lat_o     = snap_max_r;
    assign outstanding_o = occ_r;
    assign overflow_o    = ovf_r;
    assign underflow_o   = unf_r;

endmodule

// File: doc/vcache_req_latency_monitor.md
# vcache_req_latency_monitor

Passive, non-intrusive monitor on the request side of a vcache. It captures a timestamp when each packet is accepted into the cache (`v_i & ready_o`) and retires it when the matching response leaves (`v_o & yumi_i`). It accumulates request/response counts, stall cycles, total and maximum round-trip latency, and presents a registered snapshot on demand. It instantiates next to each vcache and pairs with the response-side stats profiler. The vcache returns responses in order, so a FIFO of timestamps is sufficient.

## Interface
- `data_width_p`, 32, width of snapshot tag.
- `max_out_p`, 4, depth of outstanding-request timestamp FIFO; power of 2, ≥2.
- `ctr_width_p`, 32, width of all statistic counters.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `v_i`  in  1  cache packet valid (observed).
- `ready_o`  in  1  cache ready (observed; input to this block).
- `v_o`  in  1  cache response valid (observed).
- `yumi_i`  in  1  response consumed (observed).
- `global_ctr_i`  in  32  free-running cycle counter; wraps.
- `snap_v_i`  in  1  snapshot request pulse.
- `snap_tag_i`  in  data_width_p  tag captured with snapshot.
- `snap_v_o`  out  1  one-cycle pulse: snapshot registers updated.
- `snap_tag_o`  out  data_width_p  captured tag.
- `req_count_o`, `resp_count_o`, `stall_count_o`, `total_lat_o`, `max_lat_o`  out  ctr_width_p each  snapshot of statistics.
- `outstanding_o`  out  $clog2(max_out_p)+1  live FIFO occupancy.
- `overflow_o`, `underflow_o`  out  1 each  sticky error flags.

## Operation
- accept = `v_i & ready_o`; respond = `v_o & yumi_i`; stall = `v_i & ~ready_o`.
- On accept: `req_count` +1. If FIFO is not full, or respond occurs in the same cycle, push `global_ctr_i`. If FIFO is full with no respond: the push is dropped, `overflow_o` ← 1 (sticky), and `req_count` still increments.
- On respond with FIFO non-empty: pop the head.
  - lat = `global_ctr_i - head`, modulo 2^32, zero-extended/truncated to ctr_width_p.
  - `total_lat` += lat, saturating at all-ones.
  - `max_lat` ← max(`max_lat`, lat).
  - `resp_count` +1.
- On respond with FIFO empty: `underflow_o` ← 1 (sticky). `resp_count` +1. Latency state is unchanged. A same-cycle accept still pushes; the popped entry is never the same-cycle push.
- Simultaneous push and pop: occupancy is unchanged. Head and tail pointers both advance and wrap modulo max_out_p.
- On stall: `stall_count` +1, saturating.
- `req_count` and `resp_count` wrap modulo 2^ctr_width_p.
- Snapshot: when `snap_v_i`=1 at an edge, the live counter values from *before* that edge's updates are copied to the `*_o` snapshot registers, and `snap_tag_i` to `snap_tag_o`. `snap_v_o`=1 for exactly the following cycle. Live counters are never cleared by a snapshot. Back-to-back `snap_v_i` gives back-to-back `snap_v_o` pulses.

## Timing
- Async reset (`reset_n_i`=0): all outputs, counters, pointers and flags go to 0 immediately, independent of clock. This includes reset asserted mid-operation with entries outstanding; those entries are discarded.
- Events are sampled at the rising edge. Counter effects are visible to a snapshot taken at the following edge or later.
- Latency from `snap_v_i` to valid snapshot outputs and `snap_v_o`: 1 cycle.
- `outstanding_o` reflects the registered occupancy after the edge (0..max_out_p).
- No output feeds back to the cache; the monitor never alters handshakes.

## Test plan
- Reset: hold `reset_n_i`=0 for 3 cycles, then release. All outputs = 0. Assert reset between edges with 2 outstanding → `outstanding_o`=0 without a clock edge.
- Single request: accept at ctr=10, respond at ctr=14, then snapshot with tag 0xA5. Next cycle: `snap_v_o`=1 with req=1, resp=1, total=4, max=4, tag=0xA5, `outstanding_o`=0.
- Pipelined requests: 4 accepts at ctr 20–23 and responses at 30–33 → total=40, max=10, `outstanding_o` peaks at 4. A 5th accept at full with no respond → `overflow_o`=1, req=5.
- Empty response: respond with FIFO empty → `underflow_o`=1, resp increments, total/max unchanged.
- Stalls and same-cycle push/pop: `v_i`=1, `ready_o`=0 for 3 cycles → stall=3. Accept and respond in the same cycle at occupancy 4 → occupancy stays 4, no overflow.
- Wrap: accept at ctr=0xFFFFFFFE, respond at ctr=0x00000001 → lat=3. Saturation: preload `total_lat` near all-ones (ctr_width_p=8 build), then add lat → 0xFF.
